mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//  Sequences every data-memory access for the multicycle datapath. Accepts one load/store
//  request at a time from the main control FSM and drives the DMem address, write-data and
//  enables. Waits a fixed memory latency, drives the MDR source select, and loads the MDR.
//  Signals completion with a single-cycle done pulse.
// PARAMETERS
//  DATA_WIDTH   32  data path width (MDR, DMem data, register B)
//  ADDR_WIDTH   32  byte address width
//  MEM_LATENCY  2   cycles dmem_re is held before dmem_out is valid; must be >=1 (elab check)
// PORTS
//  clk        in   1           single clock, all state updates on posedge
//  rst        in   1           synchronous, active-high reset
//  req        in   1           access request, sampled only in IDLE
//  req_write  in   1           1=store, 0=load (qualified by req)
//  req_addr   in   ADDR_WIDTH  byte address (qualified by req)
//  reg_b      in   DATA_WIDTH  register-B value: store data and MDR bypass source
//  dmem_out   in   DATA_WIDTH  data memory read port
//  dmem_addr  out  ADDR_WIDTH  latched request address
//  dmem_wdata out  DATA_WIDTH  latched reg_b
//  dmem_we    out  1           memory write strobe
//  dmem_re    out  1           memory read enable
//  mem_read   out  1           MDR source select: 1=dmem_out, 0=latched reg_b
//  mdr        out  DATA_WIDTH  memory data register
//  busy       out  1           high in every state except IDLE
//  done       out  1           1-cycle completion pulse
//  err        out  1           misaligned access; valid only while done=1
// BEHAVIOUR
//  Reset: state=IDLE; every output 0 (including mdr); wait counter 0; latched addr/data 0.
//   Reset wins over any in-flight access. A store in progress has dmem_we low in the next cycle.
//  Capture: in IDLE with req=1, latch req_addr, req_write and reg_b. req is ignored in all
//   other states, including RESP. No queueing is performed.
//  States and transitions:
//   IDLE  -> ERR    if req and req_addr[1:0]!=0. No memory strobe; mdr is unchanged.
//   IDLE  -> WRITE  if req and req_write; otherwise, with req, IDLE -> READ (counter=0).
//   WRITE -> RESP   after 1 cycle: dmem_we=1; mdr<=latched reg_b (mem_read=0).
//   READ  -> RESP   when counter==MEM_LATENCY-1. dmem_re=1 in every READ cycle; counter
//                   increments each READ cycle. mem_read=1 in the last READ cycle; mdr<=dmem_out
//                   at the end of that cycle.
//   RESP  -> IDLE   done=1 for exactly 1 cycle; err=0.
//   ERR   -> IDLE   done=1, err=1 for exactly 1 cycle.
//  Latency from the req-sampling edge:
//   store: done is high 2 cycles later.
//   load: done is high MEM_LATENCY+1 cycles later; mdr is already valid when done rises.
//   misaligned: done is high 1 cycle later.
//  dmem_addr and dmem_wdata hold the latched values from capture until the next capture.
//   Strobes are low outside WRITE/READ. dmem_we and dmem_re are never high together.
//  mem_read is 0 except in the final READ cycle.
//  Counter width is $clog2(MEM_LATENCY+1). The counter wraps to 0 on entry to READ.
//   The counter never overflows.
//  Back-to-back: a new req can be accepted in the IDLE cycle immediately after done.
// STRUCTURE
//  Shared package mem_ctrl_pkg: state enum (IDLE, READ, WRITE, RESP, ERR) and the
//   ALIGN_MASK=2'b11 constant.
//  One sub-module, mem_wait_cnt: a load/enable counter with a terminal-count flag,
//   parameterised by MEM_LATENCY.
//  FSM, latches and the MDR register stay in the top module.
// TESTING
//  1. Load, MEM_LATENCY=2: req,addr=0x10, dmem_out=0xDEADBEEF -> dmem_re high 2 cycles;
//     mdr=0xDEADBEEF; done at +3; err=0.
//  2. Store: req_write=1, addr=0x20, reg_b=0x12345678 -> dmem_we=1 for 1 cycle with
//     dmem_addr=0x20 and dmem_wdata=0x12345678; mdr=0x12345678; done at +2.
//  3. Misaligned: req at addr=0x22 -> no dmem_we/dmem_re; done=err=1 at +1; mdr unchanged.
//  4. req held high through a load plus a second req at RESP -> second access starts only
//     in the following IDLE cycle; exactly 2 done pulses.
//  5. rst asserted in the WRITE cycle -> next cycle state=IDLE, dmem_we=0, mdr=0, busy=0,
//     no done pulse.
//  6. MEM_LATENCY=1 and MEM_LATENCY=4 loads -> done at +2 and +5 respectively; dmem_re width
//     equals MEM_LATENCY.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the data-memory access controller.
package mem_ctrl_pkg;

  // Controller states: idle, multi-cycle read wait, single write strobe,
  // completion response, and misaligned-access error response.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WRITE = 3'd2,
    RESP  = 3'd3,
    ERR   = 3'd4
  } ctrlState_e;

  // Low address bits that must be zero for a word-aligned access.
  localparam logic [1:0] ALIGN_MASK = 2'b11;

  // True when the low byte-address bits select a non-word boundary.
  function automatic logic isMisaligned(input logic [1:0] lowBits);
    return (lowBits & ALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/mem_wait_cnt.sv
// Memory-latency wait counter: cleared by load, advanced by enable, and
// flags the last wait cycle (count == MEM_LATENCY-1).
module mem_wait_cnt #(
  parameter int MEM_LATENCY = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic enable,
  output logic termCount
);

  localparam int CW = (MEM_LATENCY > 0) ? $clog2(MEM_LATENCY + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(MEM_LATENCY - 1);

  logic [CW-1:0] count;

  // Counter register: load restarts the wait from zero, enable steps it once per wait cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  // Terminal count marks the final cycle of the read wait.
  always_comb begin
    termCount = (count == LAST);
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Data-memory access sequencer for the multicycle datapath: captures one
// load/store request, strobes the memory, loads the MDR and pulses done.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] reg_b,
  input  logic [DATA_WIDTH-1:0] dmem_out,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  output logic                  dmem_we,
  output logic                  dmem_re,
  output logic                  mem_read,
  output logic [DATA_WIDTH-1:0] mdr,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  if (MEM_LATENCY < 1) begin : gBadLatency
    $error("mem_access_ctrl: MEM_LATENCY must be at least 1");
  end

  ctrlState_e state;
  ctrlState_e stateNext;

  logic [ADDR_WIDTH-1:0] addrLatch;
  logic [DATA_WIDTH-1:0] regBLatch;
  logic                  capture;
  logic                  lastRead;
  logic                  mdrLoad;

  // A request is only honoured while idle; the access direction is kept
  // implicitly by which state the FSM moves into.
  always_comb begin
    capture = (state == IDLE) && req;
  end

  mem_wait_cnt #(
    .MEM_LATENCY(MEM_LATENCY)
  ) waitCnt (
    .clk      (clk),
    .rst      (rst),
    .load     (capture),
    .enable   (state == READ),
    .termCount(lastRead)
  );

  // Address and store-data latches hold from one capture to the next.
  always_ff @(posedge clk) begin
    if (rst) begin
      addrLatch <= '0;
      regBLatch <= '0;
    end else if (capture) begin
      addrLatch <= req_addr;
      regBLatch <= reg_b;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state and strobe decode; everything idles low unless a state claims it.
  always_comb begin
    stateNext = state;
    dmem_we   = 1'b0;
    dmem_re   = 1'b0;
    mem_read  = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (req) begin
          if (isMisaligned(req_addr[1:0])) begin
            stateNext = ERR;
          end else if (req_write) begin
            stateNext = WRITE;
          end else begin
            stateNext = READ;
          end
        end
      end
      WRITE: begin
        dmem_we   = 1'b1;
        stateNext = RESP;
      end
      READ: begin
        dmem_re = 1'b1;
        if (lastRead) begin
          mem_read  = 1'b1;
          stateNext = RESP;
        end
      end
      RESP: begin
        done      = 1'b1;
        stateNext = IDLE;
      end
      ERR: begin
        done      = 1'b1;
        err       = 1'b1;
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // The MDR loads once per access: the bypassed register-B value on a store,
  // or the memory read data in the final read cycle.
  always_comb begin
    mdrLoad = (state == WRITE) || ((state == READ) && lastRead);
  end

  // MDR register, source chosen by mem_read.
  always_ff @(posedge clk) begin
    if (rst) begin
      mdr <= '0;
    end else if (mdrLoad) begin
      mdr <= mem_read ? dmem_out : regBLatch;
    end
  end

  // Memory address/data ports present the captured request.
  always_comb begin
    dmem_addr  = addrLatch;
    dmem_wdata = regBLatch;
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: a main instance with MEM_LATENCY=2 plus
// MEM_LATENCY=1 and MEM_LATENCY=4 instances for the latency check, all
// talking to a small 16-word data memory.
module tb_mem_access_ctrl;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst;
  logic req, req1, req4, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] reg_b;

  logic [DW-1:0] dmem_out, dmem_out1, dmem_out4;
  logic [AW-1:0] dmem_addr, dmem_addr1, dmem_addr4;
  logic [DW-1:0] dmem_wdata, dmem_wdata1, dmem_wdata4;
  logic dmem_we, dmem_we1, dmem_we4;
  logic dmem_re, dmem_re1, dmem_re4;
  logic mem_read, mem_read1, mem_read4;
  logic [DW-1:0] mdr, mdr1, mdr4;
  logic busy, busy1, busy4;
  logic done, done1, done4;
  logic err, err1, err4;

  logic [DW-1:0] memArr [16];
  logic [DW-1:0] refMem [16];
  logic [DW-1:0] mdrModel;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .req(req), .req_write(req_write), .req_addr(req_addr),
    .reg_b(reg_b), .dmem_out(dmem_out), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_we(dmem_we), .dmem_re(dmem_re), .mem_read(mem_read), .mdr(mdr),
    .busy(busy), .done(done), .err(err));

  mem_access_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .req(req1), .req_write(req_write), .req_addr(req_addr),
    .reg_b(reg_b), .dmem_out(dmem_out1), .dmem_addr(dmem_addr1), .dmem_wdata(dmem_wdata1),
    .dmem_we(dmem_we1), .dmem_re(dmem_re1), .mem_read(mem_read1), .mdr(mdr1),
    .busy(busy1), .done(done1), .err(err1));

  mem_access_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_LATENCY(4)) dut4 (
    .clk(clk), .rst(rst), .req(req4), .req_write(req_write), .req_addr(req_addr),
    .reg_b(reg_b), .dmem_out(dmem_out4), .dmem_addr(dmem_addr4), .dmem_wdata(dmem_wdata4),
    .dmem_we(dmem_we4), .dmem_re(dmem_re4), .mem_read(mem_read4), .mdr(mdr4),
    .busy(busy4), .done(done4), .err(err4));

  // Power-on / reset contents of a memory word; word 4 (address 0x10) holds 0xDEADBEEF.
  function automatic logic [DW-1:0] initWord(input int i);
    if (i == 4) return 32'hDEADBEEF;
    return 32'hC0DE0000 | 32'(i * 32'h111);
  endfunction

  // Data memory: reset reloads the initial image, the main instance writes into it.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) memArr[i] <= initWord(i);
    end else if (dmem_we) begin
      memArr[dmem_addr[5:2]] <= dmem_wdata;
    end
  end

  assign dmem_out  = memArr[dmem_addr[5:2]];
  assign dmem_out1 = memArr[dmem_addr1[5:2]];
  assign dmem_out4 = memArr[dmem_addr4[5:2]];

  task automatic resetModel();
    for (int i = 0; i < 16; i++) refMem[i] = initWord(i);
    mdrModel = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 1'b0; req1 = 1'b0; req4 = 1'b0;
    req_write = 1'b0; req_addr = '0; reg_b = '0;
    repeat (3) @(posedge clk);
    #1;
    total++; if ({busy, done, err} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {busy, done, err}); end
    total++; if ({dmem_we, dmem_re, mem_read} !== 3'b000) begin bad++; $display("FAIL reset_strobes got=%b exp=000", {dmem_we, dmem_re, mem_read}); end
    total++; if (mdr !== 32'h0) begin bad++; $display("FAIL reset_mdr got=%h exp=0", mdr); end
    total++; if ({dmem_addr, dmem_wdata} !== 64'h0) begin bad++; $display("FAIL reset_latches got=%h exp=0", {dmem_addr, dmem_wdata}); end
    total++; if ({mdr1, mdr4, busy1, busy4} !== 66'h0) begin bad++; $display("FAIL reset_others got=%h exp=0", {mdr1, mdr4, busy1, busy4}); end
    rst = 1'b0;
    resetModel();
    @(posedge clk);
    #1;
  endtask

  // One access on the main instance starting in an IDLE cycle; checks every
  // cycle through the completion and the following IDLE cycle.
  task automatic doAccess(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input bit hold, input string tag);
    logic misal;
    int expDone;
    logic [DW-1:0] expMdr, expMdrNow;
    logic expWe, expRe, expMr, expDn, expEr, expBz;
    misal   = (addr[1:0] != 2'b00);
    expDone = misal ? 1 : (wr ? 2 : LAT + 1);
    expMdr  = misal ? mdrModel : (wr ? data : refMem[addr[5:2]]);
    req = 1'b1; req_write = wr; req_addr = addr; reg_b = data;
    for (int k = 1; k <= expDone + 1; k++) begin
      @(posedge clk);
      #1;
      if (!hold) req = 1'b0;
      req_write = 1'($urandom_range(0, 1));
      req_addr  = $urandom;
      reg_b     = $urandom;
      expWe = !misal && wr && (k == 1);
      expRe = !misal && !wr && (k <= LAT);
      expMr = !misal && !wr && (k == LAT);
      expDn = (k == expDone);
      expEr = misal && (k == expDone);
      expBz = (k <= expDone);
      expMdrNow = (k >= expDone) ? expMdr : mdrModel;
      total++; if (dmem_we !== expWe) begin bad++; $display("FAIL %s k=%0d dmem_we got=%b exp=%b", tag, k, dmem_we, expWe); end
      total++; if (dmem_re !== expRe) begin bad++; $display("FAIL %s k=%0d dmem_re got=%b exp=%b", tag, k, dmem_re, expRe); end
      total++; if (mem_read !== expMr) begin bad++; $display("FAIL %s k=%0d mem_read got=%b exp=%b", tag, k, mem_read, expMr); end
      total++; if (done !== expDn) begin bad++; $display("FAIL %s k=%0d done got=%b exp=%b", tag, k, done, expDn); end
      if (expDn) begin
        total++; if (err !== expEr) begin bad++; $display("FAIL %s k=%0d err got=%b exp=%b", tag, k, err, expEr); end
      end
      total++; if (busy !== expBz) begin bad++; $display("FAIL %s k=%0d busy got=%b exp=%b", tag, k, busy, expBz); end
      total++; if (dmem_addr !== addr) begin bad++; $display("FAIL %s k=%0d dmem_addr got=%h exp=%h", tag, k, dmem_addr, addr); end
      total++; if (dmem_wdata !== data) begin bad++; $display("FAIL %s k=%0d dmem_wdata got=%h exp=%h", tag, k, dmem_wdata, data); end
      total++; if (mdr !== expMdrNow) begin bad++; $display("FAIL %s k=%0d mdr got=%h exp=%h", tag, k, mdr, expMdrNow); end
    end
    if (wr && !misal) refMem[addr[5:2]] = data;
    mdrModel = expMdr;
  endtask

  task automatic test_load();
    doAccess(1'b0, 32'h10, 32'h0BADF00D, 1'b0, "load");
    total++; if (mdrModel !== 32'hDEADBEEF || mdr !== 32'hDEADBEEF) begin bad++; $display("FAIL load_value got=%h exp=deadbeef", mdr); end
  endtask

  task automatic test_store();
    doAccess(1'b1, 32'h20, 32'h12345678, 1'b0, "store");
    total++; if (memArr[8] !== 32'h12345678) begin bad++; $display("FAIL store_mem got=%h exp=12345678", memArr[8]); end
  endtask

  task automatic test_misaligned();
    doAccess(1'b1, 32'h22, 32'hAAAA5555, 1'b0, "misaligned");
    total++; if (memArr[8] !== 32'h12345678) begin bad++; $display("FAIL misaligned_mem got=%h exp=12345678", memArr[8]); end
  endtask

  task automatic test_back_to_back();
    doAccess(1'b0, 32'h10, 32'h01010101, 1'b1, "hold_first");
    doAccess(1'b0, 32'h20, 32'h02020202, 1'b0, "hold_second");
  endtask

  task automatic test_reset_in_write();
    req = 1'b1; req_write = 1'b1; req_addr = 32'h24; reg_b = 32'hFEEDFACE;
    @(posedge clk);
    #1;
    req = 1'b0;
    total++; if (dmem_we !== 1'b1) begin bad++; $display("FAIL rstwr_we_before got=%b exp=1", dmem_we); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    total++; if ({busy, dmem_we, done} !== 3'b000) begin bad++; $display("FAIL rstwr_state got=%b exp=000", {busy, dmem_we, done}); end
    total++; if (mdr !== 32'h0) begin bad++; $display("FAIL rstwr_mdr got=%h exp=0", mdr); end
    total++; if (dmem_addr !== 32'h0) begin bad++; $display("FAIL rstwr_addr got=%h exp=0", dmem_addr); end
    rst = 1'b0;
    resetModel();
    @(posedge clk);
    #1;
    total++; if ({busy, done, dmem_we} !== 3'b000) begin bad++; $display("FAIL rstwr_after got=%b exp=000", {busy, done, dmem_we}); end
    total++; if (memArr[9] !== initWord(9)) begin bad++; $display("FAIL rstwr_mem got=%h exp=%h", memArr[9], initWord(9)); end
  endtask

  task automatic test_latency();
    int idx;
    logic [DW-1:0] expData;
    idx = $urandom_range(0, 15);
    expData = refMem[idx];
    req1 = 1'b1; req4 = 1'b1; req_write = 1'b0;
    req_addr = 32'(idx) << 2; reg_b = $urandom;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      req1 = 1'b0; req4 = 1'b0;
      total++; if (dmem_re1 !== (k == 1)) begin bad++; $display("FAIL lat1 k=%0d dmem_re got=%b", k, dmem_re1); end
      total++; if (done1 !== (k == 2)) begin bad++; $display("FAIL lat1 k=%0d done got=%b", k, done1); end
      total++; if (dmem_re4 !== (k <= 4)) begin bad++; $display("FAIL lat4 k=%0d dmem_re got=%b", k, dmem_re4); end
      total++; if (done4 !== (k == 5)) begin bad++; $display("FAIL lat4 k=%0d done got=%b", k, done4); end
      if (k >= 2) begin
        total++; if (mdr1 !== expData) begin bad++; $display("FAIL lat1 k=%0d mdr got=%h exp=%h", k, mdr1, expData); end
      end
      if (k >= 5) begin
        total++; if (mdr4 !== expData) begin bad++; $display("FAIL lat4 k=%0d mdr got=%h exp=%h", k, mdr4, expData); end
      end
    end
  endtask

  task automatic test_random();
    logic wr;
    logic [AW-1:0] addr;
    logic [1:0] low;
    for (int n = 0; n < 40; n++) begin
      wr   = 1'($urandom_range(0, 1));
      low  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      addr = ($urandom & 32'hFFFF_FFC0) | (32'($urandom_range(0, 15)) << 2) | 32'(low);
      doAccess(wr, addr, $urandom, 1'($urandom_range(0, 1)), "random");
    end
    req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_misaligned();
    test_back_to_back();
    test_reset_in_write();
    test_latency();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
